// File: rtl/gate_pkg.sv
// Shared op codes for the logic gate unit.
package gate_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND    = 3'd0;
  localparam logic [OP_W-1:0] OP_OR     = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR    = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND   = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR    = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR   = 3'd5;
  localparam logic [OP_W-1:0] OP_PASS_A = 3'd6;
  localparam logic [OP_W-1:0] OP_NOT_A  = 3'd7;

endpackage

// File: rtl/gate_op_core.sv
// Combinational bitwise operation selected by op.
module gate_op_core
  import gate_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] r
);

  // Decode op into the selected bitwise function.
  always_comb begin
    r = '0;
    case (op)
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_NAND:   r = ~(a & b);
      OP_NOR:    r = ~(a | b);
      OP_XNOR:   r = ~(a ^ b);
      OP_PASS_A: r = a;
      OP_NOT_A:  r = ~a;
      default:   r = '0;
    endcase
  end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered bitwise logic unit with valid/ready handshake and transfer counter.
module logic_gate_unit
  import gate_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_red,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r;
  logic             accept;
  logic             consume;

  logic [WIDTH-1:0] y_q, y_d;
  logic             y_red_q, y_red_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  gate_op_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a  (a),
    .b  (b),
    .op (op),
    .r  (r)
  );

  // Handshake: the slot is free when empty or being drained this cycle.
  always_comb begin
    in_ready = !valid_q || out_ready;
    accept   = in_valid && in_ready;
    consume  = valid_q && out_ready;
  end

  // Next-state: new result overrides drain; stale data held when emptied.
  always_comb begin
    y_d     = y_q;
    y_red_d = y_red_q;
    valid_d = valid_q;
    count_d = count_q;
    if (consume) begin
      valid_d = 1'b0;
      count_d = count_q + CNT_W'(1);
    end
    if (accept) begin
      y_d     = r;
      y_red_d = &r;
      valid_d = 1'b1;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      y_red_q <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      y_q     <= y_d;
      y_red_q <= y_red_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign y         = y_q;
  assign y_red     = y_red_q;
  assign out_valid = valid_q;
  assign count     = count_q;

endmodule
